axon_spike_scanner: RTL
=======================

// Module: axon_spike_scanner
// PURPOSE
//  Downstream consumer of the scheduler SRAM. Owns the tick pointer (read_address) and clr strobe.
//  On each tick it snapshots the current 256-bit axon spike row and emits the set axon indices,
//  lowest first, one per valid/ready handshake, to the neuron-processing block.
//  When the row is fully emitted it clears that SRAM row and advances the tick pointer.
// PARAMETERS
//  NUM_AXONS  256  width of axon row / SRAM out bus
//  IDX_W      8    axon index width, log2(NUM_AXONS)
//  ADDR_W     4    SRAM row address width (16 tick slots)
// PORTS
//  clk           in   1          system clock; all logic on rising edge
//  reset         in   1          synchronous, active-high reset
//  tick          in   1          one-cycle start-of-tick strobe
//  axons         in   NUM_AXONS  SRAM out, row at read_address (combinational)
//  read_address  out  ADDR_W     current tick slot, to SRAM read_address
//  clr           out  1          one-cycle clear of row read_address, to SRAM clr
//  axon_valid    out  1          axon_index valid
//  axon_index    out  IDX_W      index of spiking axon
//  axon_ready    in   1          consumer accepts axon_index
//  scan_done     out  1          one-cycle pulse: tick row finished
//  busy          out  1          high in any state other than IDLE
//  tick_overrun  out  1          one-cycle pulse: tick dropped
// BEHAVIOUR
//  - Reset: state=IDLE, read_address=0, shadow=0, pending=0; all outputs 0.
//    Reset mid-scan aborts: no clr, no scan_done, pointer returns to 0.
//  - States: IDLE, SCAN, CLEAR.
//  - IDLE: if (tick | pending), shadow<=axons, pending<=0, go SCAN.
//  - SCAN:
//    - axon_valid = |shadow; axon_index = index of lowest set bit of shadow.
//    - On axon_valid&axon_ready: clear that bit in shadow.
//    - Go CLEAR when shadow==0, or when the handshake clears the last set bit.
//    - axon_index stays stable while valid&!ready.
//  - CLEAR (1 cycle): clr=1 and scan_done=1. read_address<=read_address+1 at cycle end,
//    wrapping 15->0. Go IDLE.
//  - Latency: tick in IDLE at cycle 0 -> axon_valid at cycle 1 if any spike.
//    Empty row -> clr/scan_done at cycle 2.
//    N spikes with ready held high -> valid in cycles 1..N, clr in cycle N+1.
//  - tick while busy: set pending if clear (no overrun). If pending is already set,
//    pulse tick_overrun and drop the tick.
//    pending is serviced on the cycle IDLE is re-entered, so back-to-back scans have a 1-cycle IDLE gap.
//  - Snapshot isolation: SRAM writes to the current row after the snapshot are not emitted,
//    and are wiped by clr. Upstream offset-15 packets land on the current row, so they are lost.
//  - axons is sampled only on the IDLE->SCAN edge; it is ignored otherwise.
//  - clr is never asserted outside CLEAR. read_address changes only at CLEAR exit or on reset.
// TESTING
//  1 reset; tick with axons=0 -> clr=1,scan_done=1 cycle 2; read_address 0->1; no axon_valid.
//  2 axons bits {3,17,255}, ready=1 -> indices 3,17,255 in cycles 1-3; clr cycle 4; read_address=1.
//  3 axons bit 5, ready low 4 cycles -> axon_index=5 held valid 4 cycles; accepted on ready; then clr.
//  4 16 empty ticks -> read_address 0..15 then wraps to 0; exactly 16 clr pulses.
//  5 tick twice during long scan -> first sets pending (no overrun); second pulses tick_overrun;
//    after CLEAR, one IDLE cycle, then a new SCAN of row+1.
//  6 reset asserted mid-SCAN (index 40 pending) -> next cycle busy=0, axon_valid=0, read_address=0,
//    no clr; axons change after snapshot -> emitted indices match snapshot only.

Source files
------------

// File: rtl/axon_spike_scanner.sv
// Tick-driven scanner: snapshots one SRAM spike row, emits set axon indices lowest-first
// over valid/ready, then clears the row and advances the tick pointer.
module axon_spike_scanner #(
  parameter int NUM_AXONS = 256,
  parameter int IDX_W     = 8,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NUM_AXONS-1:0] axons,
  output logic [ADDR_W-1:0]    read_address,
  output logic                 clr,
  output logic                 axon_valid,
  output logic [IDX_W-1:0]     axon_index,
  input  logic                 axon_ready,
  output logic                 scan_done,
  output logic                 busy,
  output logic                 tick_overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_AXONS-1:0] shadow_q, shadow_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 pending_q, pending_d;
  logic [IDX_W-1:0]     low_idx;
  logic [NUM_AXONS-1:0] clear_mask;

  // Descending sweep so the lowest set bit wins the final assignment.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_AXONS - 1; i >= 0; i--) begin
      if (shadow_q[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    clear_mask          = '0;
    clear_mask[low_idx] = 1'b1;
  end

  assign busy         = (state_q != ST_IDLE);
  assign axon_valid   = (state_q == ST_SCAN) && (|shadow_q);
  assign axon_index   = low_idx;
  assign clr          = (state_q == ST_CLEAR);
  assign scan_done    = clr;
  assign tick_overrun = busy && tick && pending_q;
  assign read_address = addr_q;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    // Only one tick can be queued; a second one while queued is dropped.
    if (busy && tick) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          shadow_d  = axons;
          pending_d = 1'b0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (axon_valid && axon_ready) shadow_d = shadow_q & ~clear_mask;
        if (shadow_d == '0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        addr_d  = addr_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      addr_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
    end
  end

endmodule
